// File: rtl/seg7_scan_mux.sv
// ---------------------------------------------------------------------------
// seg7_scan_mux
//
// Display-side consumer of the clock's six-digit 7-segment code bus. Once per
// frame it snapshots all six codes into shadow registers, then time-multiplexes
// them onto one shared active-low segment bus with active-low digit anodes.
// It also drives a blinking colon on the decimal-point line and decodes the
// code in the current slot back to BCD for on-board self-check.
//
// Parameters:
//   SCAN_DIV      clocks per digit slot (>= 2)
//   BLANK_CYCLES  anode-off cycles at the start of each slot (1 .. SCAN_DIV-1)
//   BLINK_FRAMES  frames per colon blink half-period (>= 1)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   HRM..SEC_L  7-bit segment codes, bit6=a .. bit0=g, 1 = lit
//   colon_en    enables the colon points
//   seg_n       shared segment bus, active-low
//   dp_n        decimal point / colon, active-low
//   an_n        digit anodes, active-low; an_n[5]=HRM .. an_n[0]=SEC_L
//   digit_bcd   BCD decode of the code in the current slot
//   digit_err   current slot's code is not a legal pattern
//   frame_done  one-cycle pulse on the cycle after a snapshot
// ---------------------------------------------------------------------------
module seg7_scan_mux #(
    parameter int SCAN_DIV     = 5,
    parameter int BLANK_CYCLES = 1,
    parameter int BLINK_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] HRM,
    input  logic [6:0] HRL,
    input  logic [6:0] MIN_M,
    input  logic [6:0] MIN_L,
    input  logic [6:0] SEC_M,
    input  logic [6:0] SEC_L,
    input  logic       colon_en,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [5:0] an_n,
    output logic [3:0] digit_bcd,
    output logic       digit_err,
    output logic       frame_done
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] BLANK_END  = TW'(BLANK_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [TW-1:0] tick;
    logic [2:0]    idx;
    logic [6:0]    shadow [6];
    logic [BW-1:0] blink_cnt;
    logic          blink;

    logic [6:0]    cur_code;
    logic          anode_on;

    // Scan counters, frame snapshot and colon blink. The snapshot happens on
    // the last edge of slot 5 so the new frame starts cleanly at slot 0 and
    // input changes never tear a frame that is already on the display.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick       <= '0;
            idx        <= '0;
            for (int i = 0; i < 6; i++) begin
                shadow[i] <= '0;
            end
            blink_cnt  <= '0;
            blink      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (tick == TICK_LAST) begin
                tick <= '0;
                if (idx == 3'd5) begin
                    idx        <= '0;
                    shadow[0]  <= HRM;
                    shadow[1]  <= HRL;
                    shadow[2]  <= MIN_M;
                    shadow[3]  <= MIN_L;
                    shadow[4]  <= SEC_M;
                    shadow[5]  <= SEC_L;
                    frame_done <= 1'b1;
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt <= '0;
                        blink     <= ~blink;
                    end else begin
                        blink_cnt <= blink_cnt + BW'(1);
                    end
                end else begin
                    idx <= idx + 3'd1;
                end
            end else begin
                tick <= tick + TW'(1);
            end
        end
    end

    // Select the shadow code for the slot currently being scanned.
    always_comb begin
        cur_code = shadow[0];
        case (idx)
            3'd1:    cur_code = shadow[1];
            3'd2:    cur_code = shadow[2];
            3'd3:    cur_code = shadow[3];
            3'd4:    cur_code = shadow[4];
            3'd5:    cur_code = shadow[5];
            default: cur_code = shadow[0];
        endcase
    end

    // Map the segment pattern back to BCD. An all-off code is a legal blank
    // and decodes to F without an error; anything else unknown is flagged.
    always_comb begin
        digit_bcd = 4'hE;
        digit_err = 1'b1;
        case (cur_code)
            7'h7E: begin digit_bcd = 4'd0; digit_err = 1'b0; end
            7'h30: begin digit_bcd = 4'd1; digit_err = 1'b0; end
            7'h6D: begin digit_bcd = 4'd2; digit_err = 1'b0; end
            7'h79: begin digit_bcd = 4'd3; digit_err = 1'b0; end
            7'h33: begin digit_bcd = 4'd4; digit_err = 1'b0; end
            7'h5B: begin digit_bcd = 4'd5; digit_err = 1'b0; end
            7'h5F: begin digit_bcd = 4'd6; digit_err = 1'b0; end
            7'h70: begin digit_bcd = 4'd7; digit_err = 1'b0; end
            7'h7F: begin digit_bcd = 4'd8; digit_err = 1'b0; end
            7'h7B: begin digit_bcd = 4'd9; digit_err = 1'b0; end
            7'h00: begin digit_bcd = 4'hF; digit_err = 1'b0; end
            default: begin
                digit_bcd = 4'hE;
                digit_err = 1'b1;
            end
        endcase
    end

    // Moore display drive. The leading blank cycles of each slot keep every
    // anode off so the previous digit's segments do not ghost into this one.
    // The colon sits on the dp of HRL and MIN_L (slots 1 and 3).
    always_comb begin
        anode_on = (tick >= BLANK_END);
        an_n     = 6'h3F;
        if (anode_on) begin
            an_n = ~(6'b10_0000 >> idx);
        end
        seg_n = ~cur_code;
        dp_n  = ~(colon_en & blink & anode_on & ((idx == 3'd1) | (idx == 3'd3)));
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_mux
//
// Self-checking bench for seg7_scan_mux (SCAN_DIV=5, BLANK_CYCLES=1,
// BLINK_FRAMES=2). The stimulus process pushes the expected outputs for every
// cycle into a queue, plus hand-computed spot values at chosen cycles; an
// independent monitor pops and compares on each falling edge.
// ---------------------------------------------------------------------------
module tb_seg7_scan_mux;

    typedef struct {
        int         seq;
        string      name;
        logic [6:0] seg;
        logic [5:0] an;
        logic       dp;
        logic [3:0] bcd;
        logic       err;
        logic       fd;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [6:0] din [6];
    logic       colon_en;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [5:0] an_n;
    logic [3:0] digit_bcd;
    logic       digit_err;
    logic       frame_done;

    logic [6:0] pend [6];
    logic       pend_colon;

    exp_t exp_q [$];
    exp_t spot_q [$];
    exp_t mon_e;
    exp_t mon_s;

    int compared   = 0;
    int mismatched = 0;
    int gseq       = 0;
    int c          = 0;

    logic [6:0] exp_sh [6];
    logic       exp_blink;
    int         exp_bcnt;
    logic       exp_fd;

    logic [5:0] an_tab [6];

    seg7_scan_mux #(
        .SCAN_DIV    (5),
        .BLANK_CYCLES(1),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .HRM       (din[0]),
        .HRL       (din[1]),
        .MIN_M     (din[2]),
        .MIN_L     (din[3]),
        .SEC_M     (din[4]),
        .SEC_L     (din[5]),
        .colon_en  (colon_en),
        .seg_n     (seg_n),
        .dp_n      (dp_n),
        .an_n      (an_n),
        .digit_bcd (digit_bcd),
        .digit_err (digit_err),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode table: {err, bcd}.
    function automatic logic [4:0] refDecode(input logic [6:0] code);
        case (code)
            7'h7E:   return 5'h00;
            7'h30:   return 5'h01;
            7'h6D:   return 5'h02;
            7'h79:   return 5'h03;
            7'h33:   return 5'h04;
            7'h5B:   return 5'h05;
            7'h5F:   return 5'h06;
            7'h70:   return 5'h07;
            7'h7F:   return 5'h08;
            7'h7B:   return 5'h09;
            7'h00:   return 5'h0F;
            default: return 5'h1E;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act,
                               input logic [7:0] req, input int seq);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s (seq %0d): got %02h, expected %02h", name, seq, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, plus any spot checks tagged with it.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checkOutput("seg_n", 8'(seg_n), 8'(mon_e.seg), mon_e.seq);
            checkOutput("an_n", 8'(an_n), 8'(mon_e.an), mon_e.seq);
            checkOutput("dp_n", 8'(dp_n), 8'(mon_e.dp), mon_e.seq);
            checkOutput("digit_bcd", 8'(digit_bcd), 8'(mon_e.bcd), mon_e.seq);
            checkOutput("digit_err", 8'(digit_err), 8'(mon_e.err), mon_e.seq);
            checkOutput("frame_done", 8'(frame_done), 8'(mon_e.fd), mon_e.seq);
            checkOutput("an_onehot", 8'($countones(~an_n) <= 1), 8'd1, mon_e.seq);
            while (spot_q.size() > 0 && spot_q[0].seq == mon_e.seq) begin
                mon_s = spot_q.pop_front();
                checkOutput({mon_s.name, ".seg"}, 8'(seg_n), 8'(mon_s.seg), mon_s.seq);
                checkOutput({mon_s.name, ".an"}, 8'(an_n), 8'(mon_s.an), mon_s.seq);
                checkOutput({mon_s.name, ".dp"}, 8'(dp_n), 8'(mon_s.dp), mon_s.seq);
                checkOutput({mon_s.name, ".bcd"}, 8'(digit_bcd), 8'(mon_s.bcd), mon_s.seq);
                checkOutput({mon_s.name, ".err"}, 8'(digit_err), 8'(mon_s.err), mon_s.seq);
                checkOutput({mon_s.name, ".fd"}, 8'(frame_done), 8'(mon_s.fd), mon_s.seq);
            end
        end
    end

    function automatic void modelReset();
        for (int i = 0; i < 6; i++) exp_sh[i] = 7'h00;
        exp_blink = 1'b1;
        exp_bcnt  = 0;
        exp_fd    = 1'b0;
        c         = 0;
    endfunction

    function automatic void pushExp();
        int         tk = c % 5;
        int         sl = (c / 5) % 6;
        logic       on;
        logic [4:0] d;
        exp_t       e;
        on     = (tk >= 1);
        e.seq  = gseq;
        e.name = "cycle";
        e.an   = on ? an_tab[sl] : 6'h3F;
        e.seg  = ~exp_sh[sl];
        d      = refDecode(exp_sh[sl]);
        e.err  = d[4];
        e.bcd  = d[3:0];
        e.dp   = ~(colon_en && exp_blink && on && (sl == 1 || sl == 3));
        e.fd   = exp_fd;
        exp_q.push_back(e);
    endfunction

    task automatic pushSpot(input string nm, input logic [6:0] seg, input logic [5:0] an,
                            input logic [3:0] bcd, input logic err, input logic dp,
                            input logic fd);
        exp_t e;
        e.seq  = gseq;
        e.name = nm;
        e.seg  = seg;
        e.an   = an;
        e.bcd  = bcd;
        e.err  = err;
        e.dp   = dp;
        e.fd   = fd;
        spot_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [6:0] h_m, input logic [6:0] h_l,
                                 input logic [6:0] m_m, input logic [6:0] m_l,
                                 input logic [6:0] s_m, input logic [6:0] s_l,
                                 input logic col);
        pend[0]    = h_m;
        pend[1]    = h_l;
        pend[2]    = m_m;
        pend[3]    = m_l;
        pend[4]    = s_m;
        pend[5]    = s_l;
        pend_colon = col;
    endtask

    // Advance one clock; optionally release or (asynchronously) assert reset
    // just after the edge. The snapshot model uses the inputs that were
    // present during the previous cycle, before pending inputs are driven.
    task automatic step(input bit release_rst, input bit assert_rst);
        @(posedge clk);
        #1;
        gseq++;
        if (assert_rst) begin
            rst = 1'b0;
            modelReset();
        end else if (release_rst) begin
            rst = 1'b1;
        end else if (rst) begin
            c++;
            if (c % 30 == 0) begin
                for (int i = 0; i < 6; i++) exp_sh[i] = din[i];
                exp_fd = 1'b1;
                if (exp_bcnt == 1) begin
                    exp_bcnt  = 0;
                    exp_blink = ~exp_blink;
                end else begin
                    exp_bcnt++;
                end
            end else begin
                exp_fd = 1'b0;
            end
        end
        for (int i = 0; i < 6; i++) din[i] = pend[i];
        colon_en = pend_colon;
        pushExp();
    endtask

    task automatic spotA();
        case (c)
            0:   pushSpot("A_reset_out", 7'h7F, 6'h3F, 4'hF, 1'b0, 1'b1, 1'b0);
            6:   pushSpot("A_f1_slot1",  7'h7F, 6'h2F, 4'hF, 1'b0, 1'b0, 1'b0);
            30:  pushSpot("A_f2_start",  7'h4F, 6'h3F, 4'h1, 1'b0, 1'b1, 1'b1);
            31:  pushSpot("A_f2_slot0",  7'h4F, 6'h1F, 4'h1, 1'b0, 1'b1, 1'b0);
            36:  pushSpot("A_f2_slot1",  7'h12, 6'h2F, 4'h2, 1'b0, 1'b0, 1'b0);
            41:  pushSpot("A_f2_slot2",  7'h06, 6'h37, 4'h3, 1'b0, 1'b1, 1'b0);
            56:  pushSpot("A_f2_noTear", 7'h20, 6'h3E, 4'h6, 1'b0, 1'b1, 1'b0);
            66:  pushSpot("A_f3_colon",  7'h12, 6'h2F, 4'h2, 1'b0, 1'b1, 1'b0);
            86:  pushSpot("A_f3_secl9",  7'h04, 6'h3E, 4'h9, 1'b0, 1'b1, 1'b0);
            96:  pushSpot("A_f4_colon",  7'h12, 6'h2F, 4'h2, 1'b0, 1'b1, 1'b0);
            125: pushSpot("A_f5_blank",  7'h12, 6'h3F, 4'h2, 1'b0, 1'b1, 1'b0);
            126: pushSpot("A_f5_colon",  7'h12, 6'h2F, 4'h2, 1'b0, 1'b0, 1'b0);
            156: pushSpot("A_f6_colOff", 7'h12, 6'h2F, 4'h2, 1'b0, 1'b1, 1'b0);
            191: pushSpot("A_f7_bad55",  7'h2A, 6'h37, 4'hE, 1'b1, 1'b1, 1'b0);
            221: pushSpot("A_f8_blank",  7'h7F, 6'h37, 4'hF, 1'b0, 1'b1, 1'b0);
            default: ;
        endcase
    endtask

    task automatic spotB();
        case (c)
            1:  pushSpot("B_blank_again", 7'h7F, 6'h1F, 4'hF, 1'b0, 1'b1, 1'b0);
            30: pushSpot("B_f2_start",    7'h4F, 6'h3F, 4'h1, 1'b0, 1'b1, 1'b1);
            31: pushSpot("B_f2_slot0",    7'h4F, 6'h1F, 4'h1, 1'b0, 1'b1, 1'b0);
            46: pushSpot("B_f2_slot3",    7'h4C, 6'h3B, 4'h4, 1'b0, 1'b1, 1'b0);
            default: ;
        endcase
    endtask

    // Watchdog so a stuck run still reports and terminates.
    initial begin
        #100000;
        mismatched++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        an_tab[0] = 6'h1F;
        an_tab[1] = 6'h2F;
        an_tab[2] = 6'h37;
        an_tab[3] = 6'h3B;
        an_tab[4] = 6'h3D;
        an_tab[5] = 6'h3E;
        rst = 1'b0;
        modelReset();
        applyStimulus(7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 1'b1);
        for (int i = 0; i < 6; i++) din[i] = pend[i];
        colon_en = pend_colon;

        // Phase A: 12:34:56 with colon, mid-frame SEC_L change, bad/blank codes.
        $display("[TB] phase A: scanning 12:34:56");
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        spotA();
        for (int k = 1; k <= 240; k++) begin
            if (k == 45)  applyStimulus(7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h7B, 1'b1);
            if (k == 150) applyStimulus(7'h30, 7'h6D, 7'h55, 7'h33, 7'h5B, 7'h7B, 1'b0);
            if (k == 185) applyStimulus(7'h30, 7'h6D, 7'h00, 7'h33, 7'h5B, 7'h7B, 1'b0);
            step(1'b0, 1'b0);
            spotA();
        end

        // Phase B: fresh start, then asynchronous reset mid-slot at cycle 47.
        $display("[TB] phase B: reset mid-frame");
        step(1'b0, 1'b1);
        for (int k = 0; k < 2; k++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int k = 1; k <= 46; k++) begin
            step(1'b0, 1'b0);
            spotB();
        end
        step(1'b0, 1'b1);
        pushSpot("B_async_rst", 7'h7F, 6'h3F, 4'hF, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            step(1'b0, 1'b0);
            spotB();
        end

        @(negedge clk);
        #1;
        checkOutput("queue_drained", 8'(exp_q.size() + spot_q.size()), 8'd0, gseq);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
